// File: rtl/calculadora_sequencial.sv
// rtl/calculadora_sequencial.sv - clocked calculator with accumulator and shift-add multiplier
module calculadora_sequencial #(
  parameter int LARGURA = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] entrada_A,
  input  logic [LARGURA-1:0] entrada_B,
  input  logic [2:0]         codigo,
  input  logic               inicio,
  output logic               ocupado,
  output logic [LARGURA-1:0] saida,
  output logic               pronto,
  output logic               carry,
  output logic               overflow,
  output logic               zero
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_A   = 3'b010;
  localparam logic [2:0] OP_B   = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_ACC = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b110;

  localparam int CW = $clog2(LARGURA) + 1;
  localparam logic [CW-1:0] CNT_ULTIMO = CW'(LARGURA - 1);

  typedef enum logic [1:0] {OCIOSO, EXEC, MUL} estado_t;

  estado_t estado, prox_estado;

  logic [LARGURA-1:0]   a_r, b_r, acc;
  logic [2:0]           cod_r;
  logic [2*LARGURA-1:0] prod, mcand, prod_prox;
  logic [LARGURA-1:0]   mplier;
  logic [CW-1:0]        cnt;

  logic aceita, ultimo_passo;

  logic [LARGURA:0]   soma, dif, soma_acc;
  logic [LARGURA-1:0] res;
  logic               res_c, res_v, acc_we;
  logic [LARGURA-1:0] acc_prox;

  assign aceita       = inicio && (estado == OCIOSO);
  assign ultimo_passo = (estado == MUL) && (cnt == CNT_ULTIMO);

  always_ff @(posedge clk) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO: if (aceita) prox_estado = (codigo == OP_MUL) ? MUL : EXEC;
      EXEC:   prox_estado = OCIOSO;
      MUL:    if (ultimo_passo) prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != OCIOSO);
  end

  // Single-cycle opcodes; signed overflow derived from operand/result sign bits
  always_comb begin
    soma     = {1'b0, a_r} + {1'b0, b_r};
    dif      = {1'b0, a_r} - {1'b0, b_r};
    soma_acc = {1'b0, acc} + {1'b0, a_r};
    res      = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    acc_we   = 1'b0;
    acc_prox = acc;
    case (cod_r)
      OP_ADD: begin
        res   = soma[LARGURA-1:0];
        res_c = soma[LARGURA];
        res_v = (a_r[LARGURA-1] == b_r[LARGURA-1]) && (soma[LARGURA-1] != a_r[LARGURA-1]);
      end
      OP_SUB: begin
        res   = dif[LARGURA-1:0];
        res_c = dif[LARGURA];
        res_v = (a_r[LARGURA-1] != b_r[LARGURA-1]) && (dif[LARGURA-1] != a_r[LARGURA-1]);
      end
      OP_A: res = a_r;
      OP_B: res = b_r;
      OP_ACC: begin
        res      = soma_acc[LARGURA-1:0];
        res_c    = soma_acc[LARGURA];
        res_v    = (acc[LARGURA-1] == a_r[LARGURA-1]) && (soma_acc[LARGURA-1] != acc[LARGURA-1]);
        acc_we   = 1'b1;
        acc_prox = soma_acc[LARGURA-1:0];
      end
      OP_CLR: begin
        acc_we   = 1'b1;
        acc_prox = '0;
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    prod_prox = mplier[0] ? (prod + mcand) : prod;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      cod_r    <= '0;
      acc      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      saida    <= '0;
      pronto   <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (aceita) begin
        a_r    <= entrada_A;
        b_r    <= entrada_B;
        cod_r  <= codigo;
        prod   <= '0;
        mcand  <= {{LARGURA{1'b0}}, entrada_A};
        mplier <= entrada_B;
        cnt    <= '0;
      end
      if (estado == MUL) begin
        prod   <= prod_prox;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (estado == EXEC) begin
        saida    <= res;
        carry    <= res_c;
        overflow <= res_v;
        zero     <= (res == '0);
        pronto   <= 1'b1;
        if (acc_we) acc <= acc_prox;
      end
      if (ultimo_passo) begin
        saida    <= prod_prox[LARGURA-1:0];
        carry    <= 1'b0;
        overflow <= |prod_prox[2*LARGURA-1:LARGURA];
        zero     <= (prod_prox[LARGURA-1:0] == '0);
        pronto   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calculadora_sequencial.sv
// tb/tb_calculadora_sequencial.sv - randomized self-checking bench for calculadora_sequencial
module tb_calculadora_sequencial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] entrada_A, entrada_B;
  logic [2:0]   codigo;
  logic         inicio;
  logic         ocupado, pronto, carry, overflow, zero;
  logic [W-1:0] saida;

  int checks = 0;
  int failures = 0;
  int acc_m = 0;

  calculadora_sequencial #(.LARGURA(W)) dut (
    .clk(clk), .rst_n(rst_n), .entrada_A(entrada_A), .entrada_B(entrada_B),
    .codigo(codigo), .inicio(inicio), .ocupado(ocupado), .saida(saida),
    .pronto(pronto), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic int as_signed(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic bit fora_faixa(input int x);
    return (x < -(1 << (W - 1))) || (x > (1 << (W - 1)) - 1);
  endfunction

  // Reference behaviour in plain integer arithmetic; updates the model accumulator
  function automatic void modelo(input int op, input int a, input int b,
                                 output int s, output int c, output int v);
    int m = 1 << W;
    int r;
    s = 0; c = 0; v = 0;
    case (op)
      0: begin r = a + b; s = r % m; c = (r >= m); v = fora_faixa(as_signed(a) + as_signed(b)); end
      1: begin s = (a - b + m) % m; c = (a < b); v = fora_faixa(as_signed(a) - as_signed(b)); end
      2: s = a;
      3: s = b;
      4: begin r = a * b; s = r % m; v = ((r / m) != 0); end
      5: begin
        r = acc_m + a; c = (r >= m); v = fora_faixa(as_signed(acc_m) + as_signed(a));
        acc_m = r % m; s = acc_m;
      end
      6: acc_m = 0;
      default: s = 0;
    endcase
  endfunction

  task automatic do_op(input string nome, input int op, input int a, input int b);
    int s, c, v, n, lat;
    entrada_A = W'(a); entrada_B = W'(b); codigo = 3'(op); inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    modelo(op, a, b, s, c, v);
    lat = (op == 4) ? W : 1;
    checks++;
    if (ocupado !== 1'b1) begin
      failures++; $display("FAIL %s ocupado_after_accept got=%b want=1", nome, ocupado);
    end
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (pronto !== 1'b1 && n < 40);
    checks++;
    if (n !== lat) begin
      failures++; $display("FAIL %s latency got=%0d want=%0d", nome, n, lat);
    end
    checks++;
    if ({saida, carry, overflow, zero} !== {W'(s), c[0], v[0], (s == 0)}) begin
      failures++;
      $display("FAIL %s op=%0d a=%0d b=%0d result got saida=%0d c=%b v=%b z=%b want saida=%0d c=%0d v=%0d z=%0d",
               nome, op, a, b, saida, carry, overflow, zero, s, c, v, (s == 0));
    end
    checks++;
    if (ocupado !== 1'b0) begin
      failures++; $display("FAIL %s ocupado_at_pronto got=%b want=0", nome, ocupado);
    end
    @(posedge clk); #1;
    checks++;
    if (pronto !== 1'b0) begin
      failures++; $display("FAIL %s pronto_width got=%b want=0", nome, pronto);
    end
  endtask

  task automatic test_reset;
    int np;
    rst_n = 1'b0; inicio = 1'b0; entrada_A = '0; entrada_B = '0; codigo = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ocupado, saida, pronto, carry, overflow, zero} !== '0) begin
      failures++; $display("FAIL reset_initial got=%b want=0", {ocupado, saida, pronto, carry, overflow, zero});
    end
    rst_n = 1'b1; acc_m = 0;
    do_op("acc_pre_reset", 5, 77, 0);
    entrada_A = 8'd200; entrada_B = 8'd3; codigo = 3'b100; inicio = 1'b1;
    @(posedge clk); #1; inicio = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; acc_m = 0;
    checks++;
    if ({ocupado, saida, pronto, carry, overflow, zero} !== '0) begin
      failures++; $display("FAIL reset_mid_mul got=%b want=0", {ocupado, saida, pronto, carry, overflow, zero});
    end
    rst_n = 1'b1;
    np = 0;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (pronto === 1'b1) np++;
    end
    checks++;
    if (np !== 0) begin
      failures++; $display("FAIL reset_no_pronto got=%0d want=0", np);
    end
    do_op("acc_after_reset", 5, 1, 0);
  endtask

  task automatic test_add;
    do_op("add_200_100", 0, 200, 100);
    do_op("add_100_100", 0, 100, 100);
  endtask

  task automatic test_sub;
    do_op("sub_5_7", 1, 5, 7);
    do_op("sub_9_9", 1, 9, 9);
    do_op("sub_neg_ovf", 1, 128, 1);
  endtask

  task automatic test_mul;
    do_op("mul_15_17", 4, 15, 17);
    do_op("mul_16_16", 4, 16, 16);
    do_op("mul_255_255", 4, 255, 255);
  endtask

  task automatic test_acc;
    do_op("acc_clear", 6, 33, 44);
    repeat (3) do_op("acc_add_100", 5, 100, 0);
    do_op("pass_a", 2, 0, 9);
    do_op("pass_b", 3, 12, 34);
    do_op("reserved", 7, 5, 6);
  endtask

  task automatic test_back_to_back;
    int n, s, c, v;
    entrada_A = 8'd15; entrada_B = 8'd17; codigo = 3'b100; inicio = 1'b1;
    @(posedge clk); #1;
    entrada_A = 8'd3; entrada_B = 8'd4; codigo = 3'b000;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (pronto !== 1'b1 && n < 40);
    modelo(4, 15, 17, s, c, v);
    checks++;
    if (n !== W || saida !== W'(s) || overflow !== v[0]) begin
      failures++; $display("FAIL b2b_mul got n=%0d saida=%0d v=%b want n=%0d saida=%0d v=%0d", n, saida, overflow, W, s, v);
    end
    @(posedge clk); #1;
    checks++;
    if (pronto !== 1'b0 || ocupado !== 1'b1) begin
      failures++; $display("FAIL b2b_accept got pronto=%b ocupado=%b want pronto=0 ocupado=1", pronto, ocupado);
    end
    inicio = 1'b0;
    @(posedge clk); #1;
    modelo(0, 3, 4, s, c, v);
    checks++;
    if (pronto !== 1'b1 || saida !== W'(s)) begin
      failures++; $display("FAIL b2b_add got pronto=%b saida=%0d want pronto=1 saida=%0d", pronto, saida, s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      do_op("random", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_acc;
    test_back_to_back;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
